hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside control_unit and generates stall, flush and bubble strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps shadow copies of EX- and MEM-stage destination and load information, so load-use detection needs no taps into the datapath registers.
- Runs a memory-wait state machine with timeout/fault handling for the data-memory handshake.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive cycles spent in MEM_WAIT before a fault is declared (>=1).
- TMO_W, 5, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  ID destination register
- id_RegWrite  in  1  control_unit RegWrite for the ID instruction
- id_MemRead  in  1  control_unit MemRead for the ID instruction
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
- mem_req  in  1  MEM stage performs a load or store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  load a bubble into ID/EX
- ex_mem_stall  out  1  hold ID/EX and EX/MEM
- mem_wb_bubble  out  1  load a bubble into MEM/WB
- mem_fault  out  1  sticky memory-timeout fault
- state  out  2  00 RUN, 01 MEM_WAIT, 10 FAULT

Behaviour:
- Reset:
  - state=RUN, wait counter=0, all shadow registers cleared (ex_rd=0, ex_wr=0, ex_ld=0, mem_rd=0, mem_wr=0).
  - mem_fault=0.
  - All stall, flush and bubble outputs=0 during and after reset until inputs demand otherwise.
- Strobe outputs are combinational from the current state, shadow registers and inputs; they take effect at the next clk edge. Zero-cycle latency.
- Load-use hazard (luh):
  - Asserted when id_valid & ex_ld & ex_wr & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - x0 never causes a hazard.
- Priority, highest first:
  1. FAULT
  2. memory wait
  3. redirect
  4. load-use
- RUN:
  - mem_req & !mem_ready → pc_stall=if_id_stall=ex_mem_stall=1, mem_wb_bubble=1. Next state MEM_WAIT, counter=1. A concurrent ex_redirect or luh is deferred (shadows frozen, EX instruction stays).
  - Else ex_redirect → if_id_flush=1, id_ex_flush=1. An luh in the same cycle is ignored; the ID instruction is being squashed.
  - Else luh → pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble per load-use pair.
- MEM_WAIT:
  - Same freeze outputs as entry (pc_stall, if_id_stall, ex_mem_stall, mem_wb_bubble all 1); counter increments each cycle.
  - mem_ready=1 → freeze outputs drop in that same cycle; the access completes and the pipeline advances. Next state RUN, counter=0. Redirect and luh are evaluated normally in that cycle.
  - Counter reaches MEM_TIMEOUT without mem_ready → next state FAULT, mem_fault=1.
- FAULT:
  - Outputs held: pc_stall=if_id_stall=ex_mem_stall=1, mem_wb_bubble=1.
  - Exits only via rst.
- Shadow update on each clk edge:
  - When ex_mem_stall=0: mem_{rd,wr} ← ex_{rd,wr}.
  - When ex_mem_stall=0, ex_{rd,wr,ld} ← 0 if id_ex_flush, else ← id_rd/id_RegWrite&id_valid/id_MemRead&id_valid.
  - When ex_mem_stall=1: shadows hold.
- mem_req while state=FAULT is ignored.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_luh_cnt[31:0], perf_flush_cnt[31:0] and perf_memwait_cnt[31:0].
  - Each counter increments once per cycle in which the load-use stall, the redirect flush, or a MEM_WAIT/entry freeze (respectively) is the active action.
  - Counters clear on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw x5 in EX (ex_ld=1, ex_rd=5), ID add with rs1=5 → exactly 1 cycle of pc_stall=if_id_stall=id_ex_flush=1; next cycle all 0 (ex_ld cleared by the bubble).
- x0 and unused-source cases: load to x0 with consumer rs1=0, then load x7 with id_use_rs2=0 and rs2=7 → no stall in either case.
- Redirect vs luh: ex_redirect=1 with luh also true → if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → state 01 for 3 cycles with freeze outputs=1; in the ready cycle outputs=0; state=00 on the next edge.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → FAULT (state=10) and mem_fault=1 after 4 wait cycles; the state persists; rst mid-FAULT returns to RUN with all outputs 0 on the following cycle.
- Wait with pending redirect: ex_redirect=1 during MEM_WAIT → no flush until the cycle mem_ready=1, then if_id_flush=id_ex_flush=1.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Pipeline stall/flush/bubble sequencer with load-use detection and a data-memory wait/timeout FSM.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_RegWrite,
  input  logic       id_MemRead,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_bubble,
  output logic       mem_fault,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_luh_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_memwait_cnt,
`endif
  output logic [1:0] state
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [4:0]       ex_rd_q, mem_rd_q;
  logic             ex_wr_q, ex_ld_q, mem_wr_q;

  logic luh, freeze, act_redirect, act_luh;

  assign luh = id_valid & ex_ld_q & ex_wr_q & (ex_rd_q != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = ST_WAIT;
          cnt_d   = TMO_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LIM) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RUN;
    endcase
  end

  // Output logic: freeze beats redirect, redirect beats load-use
  always_comb begin
    freeze = (state_q == ST_FAULT) |
             ((state_q == ST_WAIT) & !mem_ready) |
             ((state_q == ST_RUN) & mem_req & !mem_ready);
    act_redirect  = !freeze & ex_redirect;
    act_luh       = !freeze & !ex_redirect & luh;
    pc_stall      = freeze | act_luh;
    if_id_stall   = freeze | act_luh;
    if_id_flush   = act_redirect;
    id_ex_flush   = act_redirect | act_luh;
    ex_mem_stall  = freeze;
    mem_wb_bubble = freeze;
  end

  assign state     = state_q;
  assign mem_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd_q  <= '0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
    end else if (!ex_mem_stall) begin
      mem_rd_q <= ex_rd_q;
      mem_wr_q <= ex_wr_q;
      if (id_ex_flush) begin
        ex_rd_q <= '0;
        ex_wr_q <= 1'b0;
        ex_ld_q <= 1'b0;
      end else begin
        ex_rd_q <= id_rd;
        ex_wr_q <= id_RegWrite & id_valid;
        ex_ld_q <= id_MemRead & id_valid;
      end
    end
  end

  // MEM-stage shadow has no consumer inside this block yet
  logic unused_mem_shadow;
  assign unused_mem_shadow = ^{mem_rd_q, mem_wr_q};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] luh_cnt_q, flush_cnt_q, memwait_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      luh_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (act_luh)                          luh_cnt_q     <= luh_cnt_q + 32'd1;
      if (act_redirect)                     flush_cnt_q   <= flush_cnt_q + 32'd1;
      if (freeze && (state_q != ST_FAULT))  memwait_cnt_q <= memwait_cnt_q + 32'd1;
    end
  end
  assign perf_luh_cnt     = luh_cnt_q;
  assign perf_flush_cnt   = flush_cnt_q;
  assign perf_memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler (MEM_TIMEOUT=4): load-use, x0, redirect priority, memory wait and timeout.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_RegWrite, id_MemRead;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic       ex_mem_stall, mem_wb_bubble, mem_fault;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view: {pc, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, wb_bubble, fault, state[1:0]}
  localparam logic [8:0] ZERO  = 9'b0000000_00;
  localparam logic [8:0] LUH   = 9'b1101000_00;
  localparam logic [8:0] REDIR = 9'b0011000_00;
  localparam logic [8:0] FRZ_R = 9'b1100110_00;
  localparam logic [8:0] FRZ_W = 9'b1100110_01;
  localparam logic [8:0] RDY_W = 9'b0000000_01;
  localparam logic [8:0] LUH_W = 9'b1101000_01;
  localparam logic [8:0] RED_W = 9'b0011000_01;
  localparam logic [8:0] FLT   = 9'b1100111_10;

  hazard_scheduler #(.MEM_TIMEOUT(4), .TMO_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .mem_fault(mem_fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
           mem_wb_bubble, mem_fault, state};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("[TB] %-12s out=%b exp=%b", tag, obs, exp);
  endtask

  // Drive one cycle of inputs on the falling edge, then check the combinational outputs
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic mr,
                      input logic redir, input logic req, input logic rdy,
                      input logic [8:0] exp, input logic do_chk);
    @(negedge clk);
    rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_RegWrite = rw; id_MemRead = mr;
    ex_redirect = redir; mem_req = req; mem_ready = rdy;
    #1;
    if (do_chk) chk(tag, exp);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_RegWrite = 0; id_MemRead = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    //          tag            r  v  rs1 u1 rs2 u2 rd rw mr rd rq rdy exp   chk
    step("reset",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  1);
    step("lw_x5",         0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, ZERO,  1);
    step("luh_rs1",       0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, LUH,   1);
    step("luh_once",      0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, ZERO,  1);
    step("lw_x0",         0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ZERO,  1);
    step("x0_nohaz",      0, 1, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, ZERO,  1);
    step("unused_rs2",    0, 1, 3, 1, 7, 0, 8, 1, 0, 0, 0, 0, ZERO,  1);
    step("lw_x9",         0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, ZERO,  1);
    step("luh_rs2",       0, 1, 1, 1, 9, 1, 2, 1, 0, 0, 0, 0, LUH,   1);
    step("lw_x5b",        0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, ZERO,  1);
    step("redir_vs_luh",  0, 1, 5, 1, 0, 0, 4, 1, 0, 1, 0, 0, REDIR, 1);
    step("wait_entry",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_R, 1);
    step("wait_1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("wait_2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("wait_ready",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RDY_W, 1);
    step("wait_done",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  1);
    step("lw_x5c",        0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, ZERO,  1);
    step("defer_entry",   0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ_R, 1);
    step("defer_wait",    0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ_W, 1);
    step("luh_at_ready",  0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, LUH_W, 1);
    step("luh_cleared",   0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  1);
    step("rw_entry",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ_R, 1);
    step("rw_wait",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ_W, 1);
    step("rw_ready",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, RED_W, 1);
    step("lw_x5d",        0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, ZERO,  1);
    step("tmo_entry",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_R, 1);
    step("tmo_w1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("tmo_w2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("tmo_w3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("tmo_w4",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_W, 1);
    step("fault",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FLT,   1);
    step("fault_sticky",  0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 1, FLT,   1);
    step("fault_rst",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  0);
    step("post_rst",      0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
